// File: rtl/alu_reservation_station_if.sv
// alu_reservation_station_if: dispatcher issue, CDB broadcast and ALU launch signals of the ALU reservation station.
interface alu_reservation_station_if #(
    parameter int ROB_ID_WIDTH = 4
);
    logic                    issue_valid;
    logic [5:0]              issue_openum;
    logic [31:0]             issue_V1, issue_V2, issue_imm, issue_pc;
    logic [ROB_ID_WIDTH-1:0] issue_Q1, issue_Q2, issue_rob_id;
    logic                    issue_Q1_busy, issue_Q2_busy;
    logic                    full;
    logic                    alu_cdb_valid, lsb_cdb_valid;
    logic [ROB_ID_WIDTH-1:0] alu_cdb_rob_id, lsb_cdb_rob_id;
    logic [31:0]             alu_cdb_value, lsb_cdb_value;
    logic [5:0]              alu_openum;
    logic [31:0]             alu_V1, alu_V2, alu_imm, alu_pc;
    logic [ROB_ID_WIDTH-1:0] alu_rob_id;
    modport master (
        output issue_valid, issue_openum, issue_V1, issue_V2, issue_imm, issue_pc,
               issue_Q1, issue_Q2, issue_rob_id, issue_Q1_busy, issue_Q2_busy,
               alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
               lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
        input  full, alu_openum, alu_V1, alu_V2, alu_imm, alu_pc, alu_rob_id
    );
    modport slave (
        input  issue_valid, issue_openum, issue_V1, issue_V2, issue_imm, issue_pc,
               issue_Q1, issue_Q2, issue_rob_id, issue_Q1_busy, issue_Q2_busy,
               alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
               lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
        output full, alu_openum, alu_V1, alu_V2, alu_imm, alu_pc, alu_rob_id
    );
endinterface

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: buffers ALU/branch ops, wakes operands from both CDBs, launches one ready op per cycle.
// Optional RS_WAKEUP_BYPASS_EN lets an entry woken this cycle be selected in the same cycle.
module alu_reservation_station #(
    parameter int RS_SIZE      = 16,
    parameter int ROB_ID_WIDTH = 4
) (
    input logic clk,
    input logic rst,
    input logic rdy,
    input logic rollback,
    alu_reservation_station_if.slave bus
);
    localparam int IW = $clog2(RS_SIZE);
    localparam logic [RS_SIZE-1:0] ONE = RS_SIZE'(1);

    logic [RS_SIZE-1:0]      r_busy, r_q1b, r_q2b;
    logic [5:0]              r_op  [RS_SIZE];
    logic [31:0]             r_v1  [RS_SIZE];
    logic [31:0]             r_v2  [RS_SIZE];
    logic [31:0]             r_imm [RS_SIZE];
    logic [31:0]             r_pc  [RS_SIZE];
    logic [ROB_ID_WIDTH-1:0] r_q1  [RS_SIZE];
    logic [ROB_ID_WIDTH-1:0] r_q2  [RS_SIZE];
    logic [ROB_ID_WIDTH-1:0] r_rob [RS_SIZE];
    logic [5:0]              r_o_op;
    logic [31:0]             r_o_v1, r_o_v2, r_o_imm, r_o_pc;
    logic [ROB_ID_WIDTH-1:0] r_o_rob;

    logic [RS_SIZE-1:0] w_q1b, w_q2b, w_ready;
    logic [31:0]        w_v1 [RS_SIZE];
    logic [31:0]        w_v2 [RS_SIZE];
    logic [IW-1:0]      w_sel, w_free;
    logic               w_sel_ok, w_issue, w_launch, w_i1b, w_i2b;
    logic [31:0]        w_i1, w_i2;

    // Returns {still_busy, value}; the ALU bus wins if both buses carry the tag.
    function automatic logic [32:0] wake(input logic b, input logic [ROB_ID_WIDTH-1:0] q, input logic [31:0] v);
        return (b && bus.alu_cdb_valid && q == bus.alu_cdb_rob_id) ? {1'b0, bus.alu_cdb_value} :
               (b && bus.lsb_cdb_valid && q == bus.lsb_cdb_rob_id) ? {1'b0, bus.lsb_cdb_value} : {b, v};
    endfunction

    always_comb begin
        w_q1b    = '0;
        w_q2b    = '0;
        w_ready  = '0;
        w_sel    = '0;
        w_sel_ok = 1'b0;
        w_free   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            {w_q1b[i], w_v1[i]} = wake(r_q1b[i], r_q1[i], r_v1[i]);
            {w_q2b[i], w_v2[i]} = wake(r_q2b[i], r_q2[i], r_v2[i]);
`ifdef RS_WAKEUP_BYPASS_EN
            w_ready[i] = r_busy[i] && !w_q1b[i] && !w_q2b[i];
`else
            w_ready[i] = r_busy[i] && !r_q1b[i] && !r_q2b[i];
`endif
            if (w_ready[i]) begin
                w_sel    = IW'(i);
                w_sel_ok = 1'b1;
            end
            if (!r_busy[i]) w_free = IW'(i);
        end
        {w_i1b, w_i1} = wake(bus.issue_Q1_busy, bus.issue_Q1, bus.issue_V1);
        {w_i2b, w_i2} = wake(bus.issue_Q2_busy, bus.issue_Q2, bus.issue_V2);
    end

    assign bus.full = &r_busy;
    assign w_issue  = bus.issue_valid && !bus.full;
    assign w_launch = w_sel_ok && !rollback;

    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (w_issue && w_free == IW'(i)) begin
                    r_op[i]  <= bus.issue_openum;
                    r_v1[i]  <= w_i1;
                    r_q1[i]  <= bus.issue_Q1;
                    r_q1b[i] <= w_i1b;
                    r_v2[i]  <= w_i2;
                    r_q2[i]  <= bus.issue_Q2;
                    r_q2b[i] <= w_i2b;
                    r_imm[i] <= bus.issue_imm;
                    r_pc[i]  <= bus.issue_pc;
                    r_rob[i] <= bus.issue_rob_id;
                end else begin
                    r_v1[i]  <= w_v1[i];
                    r_q1b[i] <= w_q1b[i];
                    r_v2[i]  <= w_v2[i];
                    r_q2b[i] <= w_q2b[i];
                end
            end
        end
    end

    // Forwarded w_v1/w_v2 equal stored values unless the bypass woke the entry this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= '0;
            r_o_op  <= '0;
            r_o_v1  <= '0;
            r_o_v2  <= '0;
            r_o_imm <= '0;
            r_o_pc  <= '0;
            r_o_rob <= '0;
        end else if (rdy) begin
            r_busy  <= rollback ? '0 : (r_busy & ~(w_sel_ok ? ONE << w_sel : '0)) | (w_issue ? ONE << w_free : '0);
            r_o_op  <= w_launch ? r_op[w_sel] : '0;
            r_o_v1  <= w_launch ? w_v1[w_sel] : '0;
            r_o_v2  <= w_launch ? w_v2[w_sel] : '0;
            r_o_imm <= w_launch ? r_imm[w_sel] : '0;
            r_o_pc  <= w_launch ? r_pc[w_sel] : '0;
            r_o_rob <= w_launch ? r_rob[w_sel] : '0;
        end
    end

    assign bus.alu_openum = r_o_op;
    assign bus.alu_V1     = r_o_v1;
    assign bus.alu_V2     = r_o_v2;
    assign bus.alu_imm    = r_o_imm;
    assign bus.alu_pc     = r_o_pc;
    assign bus.alu_rob_id = r_o_rob;
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Reservation station for integer and branch operations; sits between the dispatcher and the ALU in the out-of-order core. It buffers issued instructions whose operands may still be pending and captures operand values from the ALU and LSB common data buses. Each cycle it launches at most one operand-complete instruction into the combinational ALU through a registered output stage. It flushes on misprediction rollback.

## Interface
Parameters:
- RS_SIZE, 16, number of entries; must be a power of two, at least 2
- ROB_ID_WIDTH, 4, ROB tag width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  global enable; low = freeze all state
- rollback  in  1  misprediction flush
- issue_valid  in  1  dispatcher writes one instruction this cycle
- issue_openum  in  6  operation code; 0 = NOP
- issue_V1 / issue_V2  in  32  operand values, meaningful when the matching busy flag is 0
- issue_Q1 / issue_Q2  in  ROB_ID_WIDTH  producer ROB tags
- issue_Q1_busy / issue_Q2_busy  in  1  operand still pending
- issue_imm  in  32  immediate
- issue_pc  in  32  instruction PC
- issue_rob_id  in  ROB_ID_WIDTH  destination ROB tag
- full  out  1  no free entry; dispatcher must not issue
- alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value  in  1/ROB_ID_WIDTH/32  ALU broadcast
- lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value  in  1/ROB_ID_WIDTH/32  LSB broadcast
- alu_openum  out  6  launched op; NOP when idle
- alu_V1, alu_V2, alu_imm, alu_pc  out  32  launched operands
- alu_rob_id  out  ROB_ID_WIDTH  launched tag

## Operation
Each entry holds: busy, openum, V1, Q1, Q1_busy, V2, Q2, Q2_busy, imm, pc, rob_id.

Wake-up:
- Every cycle, for each busy entry and each operand with Qx_busy=1, compare Qx against both CDBs.
- On a match, write Vx with the CDB value and clear Qx_busy.
- If both CDBs match the same tag, the ALU bus wins; this is illegal in normal operation.

Issue:
- When issue_valid=1, the instruction goes into the lowest-index free entry.
- Each issue operand with busy=1 whose tag matches a valid CDB in the same cycle is stored as ready, with the CDB value.

Select:
- Among busy entries with Q1_busy=0 and Q2_busy=0, pick the lowest index.
- The picked entry's fields are registered to the alu_* outputs and its busy bit clears at the same edge.
- If no entry is ready, alu_openum is set to NOP (0) and the other outputs are set to 0.

Full:
- full = (busy count == RS_SIZE), computed combinationally from current state.
- Issue while full is a protocol violation; the station ignores it.
- An entry freed by select becomes available for issue from the next cycle.

Rollback:
- Highest priority: clears all busy bits and sets alu_openum to NOP at the edge.
- An issue or select in the same cycle is discarded.

rdy low:
- No state changes: entries, outputs and full all hold.
- CDB inputs are ignored.

## Timing
- Reset: all busy=0, full=0, alu_openum=NOP, all other outputs 0.
- Launch latency, ready-at-issue instruction: issue at edge N, selectable in cycle N+1, on alu_* after edge N+1.
- Wake-up latency without the macro: CDB broadcast at edge N makes the entry selectable in cycle N+1; it appears on alu_* after edge N+1.
- Throughput: one launch per cycle and one issue per cycle, both possible in the same cycle.
- Outputs change only at clock edges. The ALU consumes the registered fields combinationally in the following cycle.
- Reset mid-operation: immediate clear, regardless of clk or rdy.

## Configuration
- RS_WAKEUP_BYPASS_EN defined:
  - An entry whose last pending operand matches a CDB in the current cycle counts as ready for select in that same cycle.
  - The CDB value is forwarded directly into the alu_V1/alu_V2 registers.
  - Wake-up-to-launch shortens by one cycle.
- Not defined:
  - Select considers only operand-ready state as stored at the start of the cycle.
  - Functional results are identical either way; only latency differs.

## Test plan
- Reset then idle: rst pulse, no issue -> alu_openum=0, full=0, all outputs 0 for 5 cycles.
- Ready issue: issue ADD V1=5, V2=7, rob_id=3, both busy=0 -> next edge alu_openum=ADD, alu_V1=5, alu_V2=7, alu_rob_id=3; following cycle NOP.
- CDB wake-up: issue with Q1_busy=1, Q1=2, then alu_cdb_valid, rob_id=2, value=0x10 two cycles later -> alu_V1=0x10. Launch is 1 edge after broadcast with RS_WAKEUP_BYPASS_EN, 2 edges without it.
- Same-cycle issue capture: issue with Q2_busy=1, Q2=6 while lsb_cdb_valid, rob_id=6, value=0xFF -> launches next edge with alu_V2=0xFF.
- Full: 16 issues all waiting on tag 9 -> full=1 after 16th edge. A 17th issue_valid is ignored. A broadcast on tag 9 launches 16 ops in index order over 16 cycles, and full drops after the first launch.
- Rollback and rdy: 4 pending entries, rollback=1 -> all freed, alu_openum=NOP. With rdy=0 for 3 cycles mid-stream, outputs and entries are frozen and a CDB pulse in that window is ignored.
